// File: rtl/chimera_pkg.sv
// rtl/chimera_pkg.sv - shared register offsets, wake FSM states and reset defaults
package chimera_pkg;

    localparam logic [31:0] BootAddrRstDefault = 32'h3000_0000;

    localparam logic [31:0] WakeCtrlMsipSetOffset  = 32'h00;
    localparam logic [31:0] WakeCtrlMsipClrOffset  = 32'h04;
    localparam logic [31:0] WakeCtrlClkCtrlOffset  = 32'h08;
    localparam logic [31:0] WakeCtrlBootAddrOffset = 32'h0C;
    localparam logic [31:0] WakeCtrlWakeCntOffset  = 32'h10;

    typedef enum logic [1:0] {
        GATED    = 2'd0,
        UNGATING = 2'd1,
        RUNNING  = 2'd2
    } wake_state_e;

endpackage

// File: rtl/chimera_wake_settle_cnt.sv
// rtl/chimera_wake_settle_cnt.sv - loadable down-counter giving a one-cycle done pulse after the settle window
module chimera_wake_settle_cnt #(
    parameter int unsigned ClkSettleCycles = 4
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic load_i,
    output logic done_o
);

    localparam int unsigned CntW = $clog2(ClkSettleCycles + 1);

    logic [CntW-1:0] cnt;
    logic            armed;

    // Loaded on the accepting edge; done fires in the cycle the count has reached zero,
    // so the consumer reacts ClkSettleCycles+1 edges after the load.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt   <= '0;
            armed <= 1'b0;
        end else if (load_i) begin
            cnt   <= CntW'(ClkSettleCycles);
            armed <= 1'b1;
        end else if (armed) begin
            if (cnt == '0) begin
                armed <= 1'b0;
            end else begin
                cnt <= cnt - CntW'(1);
            end
        end
    end

    assign done_o = armed && (cnt == '0);

endmodule

// File: rtl/chimera_cluster_wake_ctrl.sv
// rtl/chimera_cluster_wake_ctrl.sv - cluster clock-ungate, msip and boot-address controller; CHIMERA_WAKE_CNT_EN adds WAKE_CNT
module chimera_cluster_wake_ctrl
    import chimera_pkg::*;
#(
    parameter int unsigned NrCores         = 9,
    parameter int unsigned ClkSettleCycles = 4,
    parameter logic [31:0] BootAddrRst     = BootAddrRstDefault,
    parameter int unsigned AddrWidth       = 5
) (
    input  logic                 soc_clk_i,
    input  logic                 rst_i,
    input  logic                 reg_valid_i,
    output logic                 reg_ready_o,
    input  logic [AddrWidth-1:0] reg_addr_i,
    input  logic                 reg_write_i,
    input  logic [31:0]          reg_wdata_i,
    output logic                 rsp_valid_o,
    output logic [31:0]          rsp_rdata_o,
    output logic                 rsp_error_o,
    output logic                 clu_clk_en_o,
    output logic [NrCores-1:0]   msip_o,
    output logic [31:0]          boot_addr_o
);

    wake_state_e          state;
    logic [NrCores-1:0]   pend;
    logic [NrCores-1:0]   mask;
    logic [AddrWidth-1:0] word_addr;
    logic                 unused_addr_lsb;
    logic                 req_fire, wr_fire, wake_req, settle_done;
    logic                 sel_set, sel_clr, sel_clk, sel_boot, sel_cnt;
    logic [31:0]          rd_data;
    logic                 acc_err;

    assign reg_ready_o     = (state != UNGATING);
    assign req_fire        = reg_valid_i && reg_ready_o;
    assign wr_fire         = req_fire && reg_write_i;
    assign mask            = reg_wdata_i[NrCores-1:0];
    assign word_addr       = {reg_addr_i[AddrWidth-1:2], 2'b00};
    assign unused_addr_lsb = ^reg_addr_i[1:0];

    assign sel_set  = (word_addr == AddrWidth'(WakeCtrlMsipSetOffset));
    assign sel_clr  = (word_addr == AddrWidth'(WakeCtrlMsipClrOffset));
    assign sel_clk  = (word_addr == AddrWidth'(WakeCtrlClkCtrlOffset));
    assign sel_boot = (word_addr == AddrWidth'(WakeCtrlBootAddrOffset));

    assign wake_req = (state == GATED) && wr_fire &&
                      ((sel_set && (|mask)) || (sel_clk && reg_wdata_i[0]));

`ifdef CHIMERA_WAKE_CNT_EN
    logic [31:0] wake_cnt;

    assign sel_cnt = (word_addr == AddrWidth'(WakeCtrlWakeCntOffset));

    always_ff @(posedge soc_clk_i or posedge rst_i) begin
        if (rst_i) begin
            wake_cnt <= '0;
        end else if (wr_fire && sel_cnt) begin
            wake_cnt <= '0;
        end else if (wake_req) begin
            wake_cnt <= wake_cnt + 32'd1;
        end
    end
`else
    assign sel_cnt = 1'b0;
`endif

    always_comb begin
        rd_data = '0;
        acc_err = 1'b0;
        if (sel_set) begin
            rd_data = 32'(msip_o);
        end else if (sel_clr) begin
            rd_data = '0;
        end else if (sel_clk) begin
            rd_data = {31'b0, clu_clk_en_o};
            // Gating with interrupts still pending would strand them on a stopped clock.
            acc_err = reg_write_i && !reg_wdata_i[0] && (state == RUNNING) && (|msip_o);
        end else if (sel_boot) begin
            rd_data = boot_addr_o;
`ifdef CHIMERA_WAKE_CNT_EN
        end else if (sel_cnt) begin
            rd_data = wake_cnt;
`endif
        end else begin
            acc_err = 1'b1;
        end
        if (reg_write_i || acc_err) begin
            rd_data = '0;
        end
    end

    chimera_wake_settle_cnt #(
        .ClkSettleCycles(ClkSettleCycles)
    ) u_settle (
        .clk_i (soc_clk_i),
        .rst_i (rst_i),
        .load_i(wake_req),
        .done_o(settle_done)
    );

    always_ff @(posedge soc_clk_i or posedge rst_i) begin
        if (rst_i) begin
            state        <= GATED;
            clu_clk_en_o <= 1'b0;
            msip_o       <= '0;
            pend         <= '0;
            boot_addr_o  <= BootAddrRst;
            rsp_valid_o  <= 1'b0;
            rsp_rdata_o  <= '0;
            rsp_error_o  <= 1'b0;
        end else begin
            rsp_valid_o <= req_fire;
            rsp_rdata_o <= req_fire ? rd_data : 32'd0;
            rsp_error_o <= req_fire && acc_err;

            case (state)
                GATED: begin
                    if (wake_req) begin
                        state        <= UNGATING;
                        clu_clk_en_o <= 1'b1;
                        pend         <= sel_set ? mask : '0;
                    end
                end
                UNGATING: begin
                    if (settle_done) begin
                        state  <= RUNNING;
                        msip_o <= msip_o | pend;
                        pend   <= '0;
                    end
                end
                RUNNING: begin
                    if (wr_fire && sel_clk && !reg_wdata_i[0] && !(|msip_o)) begin
                        state        <= GATED;
                        clu_clk_en_o <= 1'b0;
                    end
                end
                default: begin
                    state        <= GATED;
                    clu_clk_en_o <= 1'b0;
                end
            endcase

            if (wr_fire && sel_set && (state == RUNNING)) begin
                msip_o <= msip_o | mask;
            end
            if (wr_fire && sel_clr) begin
                msip_o <= msip_o & ~mask;
            end
            if (wr_fire && sel_boot) begin
                boot_addr_o <= reg_wdata_i;
            end
        end
    end

endmodule

// File: tb/tb_chimera_cluster_wake_ctrl.sv
// tb/tb_chimera_cluster_wake_ctrl.sv - directed and randomized self-checking bench for chimera_cluster_wake_ctrl
module tb_chimera_cluster_wake_ctrl;

    localparam int NC     = 9;
    localparam int SETTLE = 4;
    localparam logic [31:0] BOOT_RST = 32'h3000_0000;

    logic          clk = 1'b0;
    logic          rst;
    logic          reg_valid, reg_write;
    logic [4:0]    reg_addr;
    logic [31:0]   reg_wdata;
    logic          reg_ready_o, rsp_valid_o, rsp_error_o, clu_clk_en_o;
    logic [31:0]   rsp_rdata_o, boot_addr_o;
    logic [NC-1:0] msip_o;

    always #5 clk = ~clk;

    chimera_cluster_wake_ctrl #(
        .NrCores        (NC),
        .ClkSettleCycles(SETTLE),
        .BootAddrRst    (BOOT_RST),
        .AddrWidth      (5)
    ) dut (
        .soc_clk_i   (clk),
        .rst_i       (rst),
        .reg_valid_i (reg_valid),
        .reg_ready_o (reg_ready_o),
        .reg_addr_i  (reg_addr),
        .reg_write_i (reg_write),
        .reg_wdata_i (reg_wdata),
        .rsp_valid_o (rsp_valid_o),
        .rsp_rdata_o (rsp_rdata_o),
        .rsp_error_o (rsp_error_o),
        .clu_clk_en_o(clu_clk_en_o),
        .msip_o      (msip_o),
        .boot_addr_o (boot_addr_o)
    );

    int pass_cnt  = 0;
    int total_cnt = 0;

    // Reference model: cluster is either asleep (clock off, no interrupts) or awake.
    logic [NC-1:0] m_msip;
    logic          m_awake;
    logic [31:0]   m_boot;
    int            m_wakes;

    logic [31:0] rd, wd, exp_rd;
    logic        er, exp_er, b;
    logic [4:0]  a;
    int          op;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total_cnt++;
        assert (obs === exp) pass_cnt++;
        else $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    endtask

    task automatic do_req(input logic w, input logic [4:0] ad, input logic [31:0] d,
                          output logic [31:0] rdo, output logic ero);
        int waited = 0;
        @(negedge clk);
        reg_valid = 1'b1;
        reg_write = w;
        reg_addr  = ad;
        reg_wdata = d;
        while (reg_ready_o !== 1'b1 && waited < 40) begin
            @(negedge clk);
            waited++;
        end
        if (waited >= 40) check("ready_timeout", 32'(waited), 32'd0);
        @(posedge clk);
        #1;
        reg_valid = 1'b0;
        check("rsp_valid", 32'(rsp_valid_o), 32'd1);
        rdo = rsp_rdata_o;
        ero = rsp_error_o;
    endtask

    // Called right after a waking write was accepted: clock first, interrupts SETTLE+1 edges later.
    task automatic settle_check(input logic [NC-1:0] pend);
        check("wake_clk_en", 32'(clu_clk_en_o), 32'd1);
        check("wake_ready0", 32'(reg_ready_o), 32'd0);
        check("wake_msip0", 32'(msip_o), 32'd0);
        for (int k = 1; k <= SETTLE; k++) begin
            @(posedge clk);
            #1;
            check("settle_ready", 32'(reg_ready_o), 32'd0);
            check("settle_msip", 32'(msip_o), 32'd0);
        end
        @(posedge clk);
        #1;
        check("woke_msip", 32'(msip_o), 32'(pend));
        check("woke_ready", 32'(reg_ready_o), 32'd1);
        m_msip  = pend;
        m_awake = 1'b1;
        m_wakes++;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1);
    end

    initial begin
        rst = 1'b1; reg_valid = 1'b0; reg_write = 1'b0; reg_addr = '0; reg_wdata = '0;
        m_msip = '0; m_awake = 1'b0; m_boot = BOOT_RST; m_wakes = 0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_clk_en", 32'(clu_clk_en_o), 32'd0);
        check("rst_msip", 32'(msip_o), 32'd0);
        check("rst_ready", 32'(reg_ready_o), 32'd1);
        check("rst_rsp_valid", 32'(rsp_valid_o), 32'd0);
        check("rst_boot", boot_addr_o, BOOT_RST);
        @(negedge clk);
        rst = 1'b0;

        do_req(1'b0, 5'h0C, 32'h0, rd, er);
        check("rd_boot_rst", rd, BOOT_RST);
        do_req(1'b0, 5'h08, 32'h0, rd, er);
        check("rd_clk_rst", rd, 32'd0);

        // Cold wake
        do_req(1'b1, 5'h00, 32'h005, rd, er);
        check("cold_err", 32'(er), 32'd0);
        settle_check(9'h005);
`ifdef CHIMERA_WAKE_CNT_EN
        do_req(1'b0, 5'h10, 32'h0, rd, er);
        check("wake_cnt1", rd, 32'd1);
`endif

        // Warm set / clear
        do_req(1'b1, 5'h00, 32'h100, rd, er);
        check("warm_set", 32'(msip_o), 32'h105);
        do_req(1'b1, 5'h04, 32'h001, rd, er);
        check("warm_clr", 32'(msip_o), 32'h104);
        do_req(1'b1, 5'h00, 32'hFFFF_FE00, rd, er);
        check("set_high_bits", 32'(msip_o), 32'h104);

        // Illegal gate, then legal gate
        do_req(1'b1, 5'h08, 32'h0, rd, er);
        check("gate_busy_err", 32'(er), 32'd1);
        check("gate_busy_clk", 32'(clu_clk_en_o), 32'd1);
        do_req(1'b1, 5'h04, 32'h1FF, rd, er);
        do_req(1'b1, 5'h08, 32'h0, rd, er);
        check("gate_ok_err", 32'(er), 32'd0);
        check("gate_ok_clk", 32'(clu_clk_en_o), 32'd0);
        do_req(1'b0, 5'h08, 32'h0, rd, er);
        check("gated_rd_clk", rd, 32'd0);
        m_msip = '0; m_awake = 1'b0;

        // A read issued during settle is held until ready returns
        do_req(1'b1, 5'h00, 32'h00A, rd, er);
        do_req(1'b0, 5'h00, 32'h0, rd, er);
        check("stall_rd", rd, 32'h00A);
        check("stall_err", 32'(er), 32'd0);
        m_msip = 9'h00A; m_awake = 1'b1; m_wakes++;
        do_req(1'b0, 5'h14, 32'h0, rd, er);
        check("bad_addr_err", 32'(er), 32'd1);
        check("bad_addr_rd", rd, 32'd0);
`ifndef CHIMERA_WAKE_CNT_EN
        do_req(1'b0, 5'h10, 32'h0, rd, er);
        check("cnt_absent_err", 32'(er), 32'd1);
`endif

        // Randomized traffic against the model
        for (int i = 0; i < 80; i++) begin
            op = $urandom_range(0, 6);
            wd = $urandom;
            if ($urandom_range(0, 3) == 0) wd = wd & 32'hFFFF_FE00;
            if (op == 1 && $urandom_range(0, 2) == 0) wd = 32'hFFFF_FFFF;
            exp_rd = 32'd0;
            exp_er = 1'b0;
            case (op)
                0: begin
                    do_req(1'b1, 5'(32'h00 | $urandom_range(0, 3)), wd, rd, er);
                    if (!m_awake && wd[NC-1:0] != '0) settle_check(wd[NC-1:0]);
                    else if (m_awake) m_msip = m_msip | wd[NC-1:0];
                end
                1: begin
                    do_req(1'b1, 5'(32'h04 | $urandom_range(0, 3)), wd, rd, er);
                    m_msip = m_msip & ~wd[NC-1:0];
                end
                2: begin
                    do_req(1'b0, 5'(32'h00 | $urandom_range(0, 3)), wd, rd, er);
                    exp_rd = 32'(m_msip);
                end
                3: begin
                    do_req(1'b1, 5'h0C, wd, rd, er);
                    m_boot = wd;
                end
                4: begin
                    do_req(1'b0, 5'(32'h0C | $urandom_range(0, 3)), wd, rd, er);
                    exp_rd = m_boot;
                end
                5: begin
                    b = 1'($urandom_range(0, 1));
                    wd[0] = b;
                    do_req(1'b1, 5'h08, wd, rd, er);
                    if (!m_awake && b) settle_check('0);
                    else if (m_awake && !b) begin
                        if (m_msip == '0) m_awake = 1'b0;
                        else exp_er = 1'b1;
                    end
                end
                default: begin
                    a = 5'(($urandom_range(5, 7) << 2) | $urandom_range(0, 3));
                    do_req(1'($urandom_range(0, 1)), a, wd, rd, er);
                    exp_er = 1'b1;
                end
            endcase
            check("rnd_rdata", rd, exp_rd);
            check("rnd_error", 32'(er), 32'(exp_er));
            check("rnd_msip", 32'(msip_o), 32'(m_msip));
            check("rnd_clk_en", 32'(clu_clk_en_o), 32'(m_awake));
            check("rnd_boot", boot_addr_o, m_boot);
        end

        // Reset in the middle of settle
        do_req(1'b1, 5'h04, 32'h1FF, rd, er);
        do_req(1'b1, 5'h08, 32'h0, rd, er);
        check("pre_rst_gated", 32'(clu_clk_en_o), 32'd0);
        do_req(1'b1, 5'h00, 32'h1F3, rd, er);
        @(posedge clk);
        #1;
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        check("async_rst_clk_en", 32'(clu_clk_en_o), 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        m_msip = '0; m_awake = 1'b0; m_boot = BOOT_RST;
        for (int k = 0; k < 8; k++) begin
            @(posedge clk);
            #1;
            check("post_rst_msip", 32'(msip_o), 32'd0);
            check("post_rst_clk", 32'(clu_clk_en_o), 32'd0);
        end
        do_req(1'b0, 5'h0C, 32'h0, rd, er);
        check("post_rst_boot", rd, BOOT_RST);
        do_req(1'b1, 5'h08, 32'h1, rd, er);
        settle_check('0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
